// File: rtl/echo_tap_mixer.sv
// Read side of the multi-tap echo delay line. On each new dry sample this block walks
// the taps one per clock with a geometrically decaying gain, then emits one saturated sample.
module echo_tap_mixer #(
    parameter int NUM_TAPS = 64,
    parameter int TAP_W    = 16,
    parameter int ACC_W    = 24
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic                                 sample_valid,
    input  logic signed [TAP_W-1:0]              dry_in,
    input  logic        [NUM_TAPS*TAP_W-1:0]     taps,
    input  logic        [$clog2(NUM_TAPS+1)-1:0] tap_count,
    input  logic        [7:0]                    decay,
    output logic signed [TAP_W-1:0]              out_sample,
    output logic                                 out_valid,
    output logic                                 busy,
    output logic                                 overrun
);

    localparam int IDX_W = $clog2(NUM_TAPS);
    localparam int CNT_W = $clog2(NUM_TAPS + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [CNT_W-1:0]        N_MAX   = CNT_W'(NUM_TAPS);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (TAP_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (TAP_W - 1)));

    function automatic logic signed [ACC_W-1:0] sext_tap(input logic signed [TAP_W-1:0] v);
        return ACC_W'(v);
    endfunction

    function automatic logic signed [TAP_W-1:0] sat_acc(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) begin
            return TAP_W'(SAT_MAX);
        end else if (v < SAT_MIN) begin
            return TAP_W'(SAT_MIN);
        end else begin
            return v[TAP_W-1:0];
        end
    endfunction

    logic        [1:0]       state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic        [7:0]       gain_q, gain_d;
    logic        [7:0]       decay_q, decay_d;
    logic        [IDX_W-1:0] idx_q, idx_d;
    logic        [CNT_W-1:0] n_q, n_d;
    logic signed [TAP_W-1:0] out_sample_q, out_sample_d;
    logic                    out_valid_q, out_valid_d;
    logic                    overrun_q, overrun_d;

    logic signed [TAP_W-1:0] tap_arr [NUM_TAPS];
    logic signed [TAP_W-1:0] tap_cur;
    logic signed [TAP_W+8:0] prod;
    logic signed [ACC_W-1:0] term;
    logic        [7:0]       gain_next;

    genvar k;
    generate
        for (k = 0; k < NUM_TAPS; k++) begin : g_tap
            assign tap_arr[k] = taps[k*TAP_W +: TAP_W];
        end
    endgenerate

    // Gain is zero-extended so the product stays signed; >>> floors toward -inf.
    assign tap_cur   = tap_arr[idx_q];
    assign prod      = tap_cur * $signed({1'b0, gain_q});
    assign term      = ACC_W'(prod >>> 8);
    assign gain_next = 8'(({8'd0, gain_q} * {8'd0, decay_q}) >> 8);

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        gain_d       = gain_q;
        decay_d      = decay_q;
        idx_d        = idx_q;
        n_d          = n_q;
        out_sample_d = out_sample_q;
        out_valid_d  = 1'b0;
        overrun_d    = overrun_q;

        case (state_q)
            IDLE: begin
                if (sample_valid) begin
                    acc_d   = sext_tap(dry_in);
                    gain_d  = decay;
                    decay_d = decay;
                    idx_d   = '0;
                    n_d     = (tap_count > N_MAX) ? N_MAX : tap_count;
                    if (n_d == '0) begin
                        state_d      = DONE;
                        out_sample_d = sat_acc(acc_d);
                        out_valid_d  = 1'b1;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                acc_d  = acc_q + term;
                gain_d = gain_next;
                idx_d  = idx_q + 1'b1;
                // The result is registered on the edge into DONE so out_sample and
                // out_valid appear together during the DONE cycle.
                if (CNT_W'(idx_q) == n_q - 1'b1) begin
                    state_d      = DONE;
                    out_sample_d = sat_acc(acc_d);
                    out_valid_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (sample_valid && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            gain_q       <= '0;
            decay_q      <= '0;
            idx_q        <= '0;
            n_q          <= '0;
            out_sample_q <= '0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            gain_q       <= gain_d;
            decay_q      <= decay_d;
            idx_q        <= idx_d;
            n_q          <= n_d;
            out_sample_q <= out_sample_d;
            out_valid_q  <= out_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign out_sample = out_sample_q;
    assign out_valid  = out_valid_q;
    assign busy       = (state_q != IDLE);
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_echo_tap_mixer.sv
// Bench for echo_tap_mixer: table vectors, random vectors against a reference model,
// and hand-written overrun / reset corner sequences, all scored through an output queue.
module tb_echo_tap_mixer;

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic               sample_valid = 1'b0;
    logic signed [15:0] dry_in = '0;
    logic [1023:0]      taps = '0;
    logic [6:0]         tap_count = '0;
    logic [7:0]         decay = '0;
    logic signed [15:0] out_sample;
    logic               out_valid;
    logic               busy;
    logic               overrun;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic signed [15:0] val;
        int                 cyc;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        int dry;
        int cnt;
        int dec;
        int tap;
        int exp_out;
    } vec_t;
    vec_t vecs[6];

    echo_tap_mixer dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .sample_valid (sample_valid),
        .dry_in       (dry_in),
        .taps         (taps),
        .tap_count    (tap_count),
        .decay        (decay),
        .out_sample   (out_sample),
        .out_valid    (out_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic int model(input int dry, input int cnt, input int dec, input logic [1023:0] t);
        int acc;
        int g;
        int n;
        int p;
        logic signed [15:0] s;
        acc = dry;
        g = dec;
        n = (cnt > 64) ? 64 : cnt;
        for (int k = 0; k < n; k++) begin
            s = t[k*16 +: 16];
            p = int'(s) * g;
            acc = acc + (p >>> 8);
            g = (g * dec) / 256;
        end
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        return acc;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Every out_valid must match the oldest queued expectation in value and cycle.
    always @(negedge clock) begin
        if (reset_n && out_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out_valid actual=%0d required=none cyc=%0d", out_sample, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("out_sample", int'(out_sample), int'(e.val));
                check("out_latency_cyc", cyc, e.cyc);
            end
        end
    end

    task automatic fill_all(input int v);
        for (int k = 0; k < 64; k++) taps[k*16 +: 16] = 16'(v);
    endtask

    task automatic strobe(input int dry, input int cnt, input int dec, input int expv);
        exp_t e;
        int n;
        @(negedge clock);
        n = (cnt > 64) ? 64 : cnt;
        dry_in = 16'(dry);
        tap_count = 7'(cnt);
        decay = 8'(dec);
        sample_valid = 1'b1;
        e.val = 16'(expv);
        e.cyc = cyc + n + 1;
        sb_q.push_back(e);
        @(negedge clock);
        sample_valid = 1'b0;
        check("busy_after_strobe", int'(busy), 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clock);
        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d required=0 pending", sb_q.size());
            sb_q.delete();
        end
        @(negedge clock);
        check("busy_idle_after_mix", int'(busy), 0);
    endtask

    initial begin
        int d, c, g, ev;

        vecs[0] = '{dry: 1000,   cnt: 0, dec: 0,   tap: 0,      exp_out: 1000};
        vecs[1] = '{dry: 0,      cnt: 1, dec: 128, tap: 2000,   exp_out: 1000};
        vecs[2] = '{dry: 0,      cnt: 3, dec: 128, tap: 4096,   exp_out: 3584};
        vecs[3] = '{dry: 30000,  cnt: 1, dec: 255, tap: 32767,  exp_out: 32767};
        vecs[4] = '{dry: -30000, cnt: 1, dec: 255, tap: -32768, exp_out: -32768};
        vecs[5] = '{dry: 100,    cnt: 2, dec: 0,   tap: 5000,   exp_out: 100};

        repeat (3) @(negedge clock);
        check("reset_out_sample", int'(out_sample), 0);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_overrun", int'(overrun), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        for (int i = 0; i < 6; i++) begin
            fill_all(vecs[i].tap);
            strobe(vecs[i].dry, vecs[i].cnt, vecs[i].dec, vecs[i].exp_out);
            drain();
        end

        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 64; k++) taps[k*16 +: 16] = 16'($urandom);
            d = int'($signed(16'($urandom)));
            c = (i == 0) ? 64 : int'($urandom_range(0, 70));
            g = int'($urandom_range(0, 255));
            ev = model(d, c, g, taps);
            strobe(d, c, g, ev);
            drain();
        end
        check("overrun_still_clear", int'(overrun), 0);

        // Clamp to 64 taps, and a second strobe mid-mix must be dropped.
        for (int k = 0; k < 64; k++) taps[k*16 +: 16] = 16'(k * 1237 - 30000);
        ev = model(7, 70, 255, taps);
        strobe(7, 70, 255, ev);
        repeat (9) @(negedge clock);
        dry_in = 16'sd12345;
        tap_count = 7'd0;
        decay = 8'd17;
        sample_valid = 1'b1;
        @(negedge clock);
        sample_valid = 1'b0;
        check("overrun_set", int'(overrun), 1);
        drain();
        repeat (5) @(negedge clock);
        check("overrun_sticky", int'(overrun), 1);

        // Reset in the middle of a 64-tap mix: outputs clear at once, no result follows.
        fill_all(300);
        @(negedge clock);
        dry_in = 16'sd555;
        tap_count = 7'd64;
        decay = 8'd200;
        sample_valid = 1'b1;
        @(negedge clock);
        sample_valid = 1'b0;
        repeat (19) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("midreset_out_sample", int'(out_sample), 0);
        check("midreset_busy", int'(busy), 0);
        check("midreset_overrun", int'(overrun), 0);
        check("midreset_out_valid", int'(out_valid), 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (70) @(negedge clock);
        strobe(-5, 0, 0, -5);
        drain();

        // Strobe landing on the DONE cycle is dropped and flags overrun.
        check("overrun_cleared_by_reset", int'(overrun), 0);
        strobe(3, 0, 0, 3);
        dry_in = 16'sd999;
        sample_valid = 1'b1;
        @(negedge clock);
        sample_valid = 1'b0;
        check("overrun_on_done", int'(overrun), 1);
        drain();
        repeat (5) @(negedge clock);
        check("out_held", int'(out_sample), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
